// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type and select-width helper for the APB master bridge
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/apb_slave_mux.sv
// apb_slave_mux: picks prdata/pready/pslverr of slave idx; out-of-range idx yields zeros
//  idx     in   SEL_W            selected slave
//  prdata  in   NUM_SLV*DATA_W   per-slave read data
//  pready  in   NUM_SLV          per-slave ready
//  pslverr in   NUM_SLV          per-slave error
//  rdata/ready/err  out          selected slave's signals
module apb_slave_mux #(
  parameter int NUM_SLV = 2,
  parameter int DATA_W = 8,
  parameter int SEL_W = 1
) (
  input  logic [SEL_W-1:0]          idx,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ready,
  output logic                      err
);
  always_comb begin
    rdata = '0;
    ready = 1'b0;
    err = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx == SEL_W'(i)) begin
        rdata = prdata[i*DATA_W +: DATA_W];
        ready = pready[i];
        err = pslverr[i];
      end
    end
  end
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready request port to multi-slave APB master with decode error and timeout
//  clk, preset                  clock, async active-high reset
//  req_valid/ready/write/addr/wdata   request port (ready only in IDLE)
//  rsp_valid/rdata/err          one-cycle response
//  psel/penable/pwrite/paddr/pwdata   APB master outputs
//  prdata/pready/pslverr        per-slave APB inputs
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int NUM_SLV = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      preset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);
  localparam int SEL_W = sel_w(NUM_SLV);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic err_q, err_n, pwrite_n, dec_err, s_ready, s_err;
  logic [DATA_W-1:0] rdata_q, rdata_n, pwdata_n, s_rdata;
  logic [ADDR_W-1:0] paddr_n;
  logic [SEL_W-1:0] idx, req_idx;
  // The latched paddr carries the slave index for the whole transfer.
  assign req_idx = (NUM_SLV == 1) ? '0 : req_addr[ADDR_W-1 -: SEL_W];
  assign idx = (NUM_SLV == 1) ? '0 : paddr[ADDR_W-1 -: SEL_W];
  assign dec_err = 32'(req_idx) >= NUM_SLV;
  apb_slave_mux #(.NUM_SLV(NUM_SLV), .DATA_W(DATA_W), .SEL_W(SEL_W)) u_mux (
    .idx(idx), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .rdata(s_rdata), .ready(s_ready), .err(s_err)
  );
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign rsp_err = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !pwrite) ? rdata_q : '0;
  assign penable = state == ACCESS;
  assign psel = (state == SETUP || state == ACCESS) ? NUM_SLV'(1) << idx : '0;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    err_n = err_q;
    rdata_n = rdata_q;
    paddr_n = paddr;
    pwdata_n = pwdata;
    pwrite_n = pwrite;
    case (state)
      IDLE: if (req_valid) begin
        paddr_n = req_addr;
        pwdata_n = req_wdata;
        pwrite_n = req_write;
        err_n = dec_err;
        rdata_n = '0;
        state_n = dec_err ? RESP : SETUP;
      end
      SETUP: state_n = ACCESS;
      ACCESS: if (s_ready) begin
        state_n = RESP;
        err_n = s_err;
        rdata_n = pwrite ? '0 : s_rdata;
        cnt_n = '0;
      end else if (cnt == CNT_W'(TIMEOUT)) begin
        state_n = RESP;
        err_n = 1'b1;
        cnt_n = '0;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
      cnt <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
      paddr <= '0;
      pwdata <= '0;
      pwrite <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      err_q <= err_n;
      rdata_q <= rdata_n;
      paddr <= paddr_n;
      pwdata <= pwdata_n;
      pwrite <= pwrite_n;
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scoreboard bench for the APB master bridge (2-slave and 3-slave instances)
module tb_apb_master_bridge;
  typedef struct {
    logic [7:0] rdata;
    logic err;
    int lat;
  } exp_t;
  logic clk, preset;
  logic req_valid0, req_ready0, req_write0, rsp_valid0, rsp_err0, penable0, pwrite0;
  logic [7:0] req_addr0, req_wdata0, rsp_rdata0, paddr0, pwdata0;
  logic [1:0] psel0, pready0, pslverr0;
  logic [15:0] prdata0;
  logic req_valid1, req_ready1, req_write1, rsp_valid1, rsp_err1, penable1, pwrite1;
  logic [7:0] req_addr1, req_wdata1, rsp_rdata1, paddr1, pwdata1;
  logic [2:0] psel1;
  logic [7:0] mem [0:1][0:255];
  int wait_cfg [0:1];
  logic err_cfg [0:1];
  int wcnt [0:1];
  logic [1:0] psel_log [0:127];
  logic pen_log [0:127];
  exp_t sb [$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int acc_cyc;

  apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(2), .TIMEOUT(15)) dut0 (
    .clk(clk), .preset(preset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .psel(psel0), .penable(penable0), .pwrite(pwrite0), .paddr(paddr0), .pwdata(pwdata0),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );
  apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(3), .TIMEOUT(15)) dut1 (
    .clk(clk), .preset(preset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
    .psel(psel1), .penable(penable1), .pwrite(pwrite1), .paddr(paddr1), .pwdata(pwdata1),
    .prdata(24'h33_22_11), .pready(3'b111), .pslverr(3'b000)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: register file per slave, configurable wait states and error.
  for (genvar g = 0; g < 2; g++) begin : g_slv
    assign pready0[g] = wcnt[g] >= wait_cfg[g];
    assign pslverr0[g] = err_cfg[g];
    assign prdata0[g*8 +: 8] = mem[g][paddr0];
  end
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (psel0[i] && penable0) begin
        if (pready0[i]) begin
          wcnt[i] <= 0;
          if (pwrite0) mem[i][paddr0] <= pwdata0;
        end else begin
          wcnt[i] <= wcnt[i] + 1;
        end
      end else begin
        wcnt[i] <= 0;
      end
    end
  end

  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic e, output int lat);
    int n;
    bit got;
    n = 0;
    got = 0;
    req_write0 = w;
    req_addr0 = a;
    req_wdata0 = d;
    req_valid0 = 1;
    while (!req_ready0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    acc_cyc = cyc;
    #1 req_valid0 = 0;
    lat = 0;
    rd = 'x;
    e = 'x;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      lat++;
      psel_log[lat] = psel0;
      pen_log[lat] = penable0;
      if (rsp_valid0) begin
        rd = rsp_rdata0;
        e = rsp_err0;
        got = 1;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL rsp_wait no rsp_valid within 100 cycles addr=%h", a);
    end
  endtask

  task automatic xfer1(input logic [7:0] a, output logic [7:0] rd, output logic e,
                       output int lat, output logic [2:0] psel_or, output logic [2:0] psel_first);
    bit got;
    got = 0;
    psel_or = '0;
    psel_first = 'x;
    req_write1 = 0;
    req_addr1 = a;
    req_wdata1 = 0;
    req_valid1 = 1;
    @(posedge clk);
    #1 req_valid1 = 0;
    lat = 0;
    rd = 'x;
    e = 'x;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      lat++;
      psel_or |= psel1;
      if (lat == 1) psel_first = psel1;
      if (rsp_valid1) begin
        rd = rsp_rdata1;
        e = rsp_err1;
        got = 1;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL rsp_wait1 no rsp_valid within 20 cycles addr=%h", a);
    end
  endtask

  task automatic test_reset;
    total++;
    if ({psel0, penable0, pwrite0, paddr0, pwdata0, rsp_valid0, rsp_rdata0, rsp_err0} !== '0) begin
      bad++;
      $display("FAIL reset_outs got psel=%b pen=%b pw=%b pa=%h pd=%h rv=%b rd=%h re=%b exp all 0",
               psel0, penable0, pwrite0, paddr0, pwdata0, rsp_valid0, rsp_rdata0, rsp_err0);
    end
    total++;
    if (req_ready0 !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=1", req_ready0);
    end
    total++;
    if ({psel1, penable1, rsp_valid1} !== '0) begin
      bad++;
      $display("FAIL reset_outs1 got psel=%b pen=%b rv=%b exp 0", psel1, penable1, rsp_valid1);
    end
  endtask

  task automatic test_write;
    logic [7:0] rd;
    logic e;
    int lat;
    exp_t x;
    wait_cfg[0] = 0;
    sb.push_back('{8'h00, 1'b0, 3});
    xfer(1, 8'h05, 8'hA5, rd, e, lat);
    x = sb.pop_front();
    total++;
    if (lat != x.lat || e !== x.err || rd !== x.rdata) begin
      bad++;
      $display("FAIL write_rsp got lat=%0d err=%b rd=%h exp lat=%0d err=%b rd=%h", lat, e, rd, x.lat, x.err, x.rdata);
    end
    total++;
    if (psel_log[1] !== 2'b01 || pen_log[1] !== 1'b0) begin
      bad++;
      $display("FAIL write_setup got psel=%b pen=%b exp psel=01 pen=0", psel_log[1], pen_log[1]);
    end
    total++;
    if (psel_log[2] !== 2'b01 || pen_log[2] !== 1'b1 || psel_log[3] !== 2'b00 || pen_log[3] !== 1'b0) begin
      bad++;
      $display("FAIL write_access got psel=%b/%b pen=%b/%b exp 01/00 1/0", psel_log[2], psel_log[3], pen_log[2], pen_log[3]);
    end
    total++;
    if (mem[0][8'h05] !== 8'hA5) begin
      bad++;
      $display("FAIL write_mem got=%h exp=a5", mem[0][8'h05]);
    end
  endtask

  task automatic test_wait_read;
    logic [7:0] rd;
    logic e;
    int lat;
    exp_t x;
    wait_cfg[1] = 0;
    sb.push_back('{8'h00, 1'b0, 3});
    xfer(1, 8'h83, 8'h3C, rd, e, lat);
    x = sb.pop_front();
    total++;
    if (lat != x.lat || e !== x.err || rd !== x.rdata || mem[1][8'h83] !== 8'h3C) begin
      bad++;
      $display("FAIL prep_write got lat=%0d err=%b rd=%h mem=%h exp lat=3 err=0 rd=00 mem=3c", lat, e, rd, mem[1][8'h83]);
    end
    wait_cfg[1] = 2;
    sb.push_back('{8'h3C, 1'b0, 5});
    xfer(0, 8'h83, 8'h00, rd, e, lat);
    x = sb.pop_front();
    total++;
    if (lat != x.lat || e !== x.err || rd !== x.rdata) begin
      bad++;
      $display("FAIL wait_read_rsp got lat=%0d err=%b rd=%h exp lat=%0d err=%b rd=%h", lat, e, rd, x.lat, x.err, x.rdata);
    end
    total++;
    if (psel_log[2] !== 2'b10 || pen_log[2] !== 1'b1 || pen_log[3] !== 1'b1 || pen_log[4] !== 1'b1 || pen_log[5] !== 1'b0) begin
      bad++;
      $display("FAIL wait_read_pen got psel2=%b pen=%b%b%b%b exp psel2=10 pen=1110", psel_log[2], pen_log[2], pen_log[3], pen_log[4], pen_log[5]);
    end
    wait_cfg[1] = 0;
  endtask

  task automatic test_slverr;
    logic [7:0] rd;
    logic e;
    int lat;
    exp_t x;
    err_cfg[1] = 1;
    sb.push_back('{8'h00, 1'b1, 3});
    xfer(0, 8'h83, 8'h00, rd, e, lat);
    x = sb.pop_front();
    err_cfg[1] = 0;
    total++;
    if (lat != x.lat || e !== x.err || rd !== x.rdata) begin
      bad++;
      $display("FAIL slverr_rsp got lat=%0d err=%b rd=%h exp lat=%0d err=%b rd=%h", lat, e, rd, x.lat, x.err, x.rdata);
    end
  endtask

  task automatic test_timeout;
    logic [7:0] rd;
    logic e;
    int lat;
    exp_t x;
    wait_cfg[0] = 1000;
    sb.push_back('{8'h00, 1'b1, 18});
    xfer(0, 8'h05, 8'h00, rd, e, lat);
    x = sb.pop_front();
    wait_cfg[0] = 0;
    total++;
    if (lat != x.lat || e !== x.err || rd !== x.rdata) begin
      bad++;
      $display("FAIL timeout_rsp got lat=%0d err=%b rd=%h exp lat=%0d err=%b rd=%h", lat, e, rd, x.lat, x.err, x.rdata);
    end
    total++;
    if (pen_log[2] !== 1'b1 || pen_log[17] !== 1'b1 || pen_log[18] !== 1'b0 || psel_log[18] !== 2'b00) begin
      bad++;
      $display("FAIL timeout_access got pen2=%b pen17=%b pen18=%b psel18=%b exp 1 1 0 00", pen_log[2], pen_log[17], pen_log[18], psel_log[18]);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] rd;
    logic e;
    int lat, a1;
    exp_t x;
    sb.push_back('{8'h00, 1'b0, 3});
    sb.push_back('{8'h55, 1'b0, 3});
    xfer(1, 8'h30, 8'h55, rd, e, lat);
    a1 = acc_cyc;
    x = sb.pop_front();
    total++;
    if (lat != x.lat || e !== x.err || rd !== x.rdata) begin
      bad++;
      $display("FAIL b2b_wr got lat=%0d err=%b rd=%h exp lat=%0d err=%b rd=%h", lat, e, rd, x.lat, x.err, x.rdata);
    end
    xfer(0, 8'h30, 8'h00, rd, e, lat);
    x = sb.pop_front();
    total++;
    if (lat != x.lat || e !== x.err || rd !== x.rdata) begin
      bad++;
      $display("FAIL b2b_rd got lat=%0d err=%b rd=%h exp lat=%0d err=%b rd=%h", lat, e, rd, x.lat, x.err, x.rdata);
    end
    total++;
    if (acc_cyc - a1 != 4) begin
      bad++;
      $display("FAIL b2b_spacing got=%0d exp=4", acc_cyc - a1);
    end
  endtask

  task automatic test_decode;
    logic [7:0] rd;
    logic e;
    int lat;
    logic [2:0] por, pfirst;
    exp_t x;
    @(negedge clk);
    total++;
    if (req_ready1 !== 1'b1) begin
      bad++;
      $display("FAIL dec_ready got=%b exp=1", req_ready1);
    end
    sb.push_back('{8'h00, 1'b1, 1});
    xfer1(8'hC0, rd, e, lat, por, pfirst);
    x = sb.pop_front();
    total++;
    if (lat != x.lat || e !== x.err || rd !== x.rdata || por !== 3'b000) begin
      bad++;
      $display("FAIL decode_err got lat=%0d err=%b rd=%h psel_seen=%b exp lat=%0d err=%b rd=%h psel_seen=000", lat, e, rd, por, x.lat, x.err, x.rdata);
    end
    @(negedge clk);
    sb.push_back('{8'h33, 1'b0, 3});
    xfer1(8'h80, rd, e, lat, por, pfirst);
    x = sb.pop_front();
    total++;
    if (lat != x.lat || e !== x.err || rd !== x.rdata || pfirst !== 3'b100) begin
      bad++;
      $display("FAIL slave2_read got lat=%0d err=%b rd=%h psel=%b exp lat=%0d err=%b rd=%h psel=100", lat, e, rd, pfirst, x.lat, x.err, x.rdata);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] rd;
    logic e;
    int lat, seen;
    exp_t x;
    wait_cfg[0] = 1000;
    req_write0 = 0;
    req_addr0 = 8'h10;
    req_wdata0 = 0;
    req_valid0 = 1;
    @(negedge clk);
    @(posedge clk);
    #1 req_valid0 = 0;
    repeat (3) @(negedge clk);
    total++;
    if (penable0 !== 1'b1) begin
      bad++;
      $display("FAIL mid_access got pen=%b exp=1", penable0);
    end
    preset = 1;
    #1;
    total++;
    if (psel0 !== 2'b00 || penable0 !== 1'b0 || paddr0 !== 8'h00 || rsp_valid0 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got psel=%b pen=%b paddr=%h rv=%b exp 00 0 00 0", psel0, penable0, paddr0, rsp_valid0);
    end
    @(negedge clk);
    preset = 0;
    wait_cfg[0] = 0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL mid_no_rsp got=%0d rsp strobes exp=0", seen);
    end
    sb.push_back('{8'h00, 1'b0, 3});
    xfer(1, 8'h11, 8'h77, rd, e, lat);
    x = sb.pop_front();
    total++;
    if (lat != x.lat || e !== x.err || rd !== x.rdata || mem[0][8'h11] !== 8'h77) begin
      bad++;
      $display("FAIL post_reset got lat=%0d err=%b rd=%h mem=%h exp lat=%0d err=%b rd=%h mem=77", lat, e, rd, mem[0][8'h11], x.lat, x.err, x.rdata);
    end
  endtask

  initial begin
    preset = 1;
    req_valid0 = 0;
    req_write0 = 0;
    req_addr0 = 0;
    req_wdata0 = 0;
    req_valid1 = 0;
    req_write1 = 0;
    req_addr1 = 0;
    req_wdata1 = 0;
    wait_cfg[0] = 0;
    wait_cfg[1] = 0;
    err_cfg[0] = 0;
    err_cfg[1] = 0;
    repeat (2) @(negedge clk);
    test_reset;
    preset = 0;
    @(negedge clk);
    test_write;
    test_wait_read;
    test_slverr;
    test_timeout;
    test_back_to_back;
    test_decode;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
